led_stream_rx: RTL and testbench
================================

Name: led_stream_rx

Overview:
- Receive-side decoder for the LED serial interface: takes the clock/data pair (cko/sdo) produced by the LED transmit path and recovers the per-LED 12-bit RGB words.
- Used as the on-chip loopback checker and as the front end of the LED-strip emulator in the system bench.
- Runs on one system clock (150 MHz); oversamples the slower serial clock (30 MHz nominal).
- Reports each LED word, frame completion, and length/padding errors.

Parameters:
LED_NUM, 35, LED words expected per frame
IDLE_CNT, 16, clk cycles without a cko rising edge that terminate a frame (must exceed 2x cko period in clk cycles)
IDX_W, 6, width of led_idx_o; must satisfy 2^IDX_W > LED_NUM

Ports:
clk  input  1  system clock (>= 4x cko frequency)
rst  input  1  reset; synchronous, active-high
cko_i  input  1  serial clock from LED transmitter, asynchronous to clk
sdo_i  input  1  serial data, MSB first, stable around cko rising edge
data_o  output  12  recovered {R[3:0],G[3:0],B[3:0]}
valid_o  output  1  one-cycle strobe: data_o/led_idx_o valid
led_idx_o  output  IDX_W  index of word on data_o, 0..LED_NUM-1
frame_done_o  output  1  one-cycle strobe at frame termination
len_err_o  output  1  word count/partial-word error for the last frame, valid at frame_done_o
pad_err_o  output  1  a padding nibble != 4'hF seen in current/last frame
busy_o  output  1  high while in RECV

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: all outputs 0; sync flops 0; state IDLE; armed=0.
- Synchronisation:
  - cko_i and sdo_i each pass through a 2-FF synchroniser (s1, s2); cko has a third stage s3.
  - rise = s2_cko & ~s3_cko & armed.
  - The bit is taken from s2_sdo in the same cycle.
- Arming:
  - armed is set the first cycle s2_cko==0 after reset.
  - This prevents a false edge when cko_i is high at reset release.
- Word format (24 bits per LED, MSB first): R[3:0], 4'hF, G[3:0], 4'hF, B[3:0], 4'hF.
  - data_o = bits {23:20, 15:12, 7:4}.
  - Pad nibbles {19:16, 11:8, 3:0} must be 4'hF. Otherwise pad_err_o is set and stays sticky until the next frame start.
- FSM:
  - IDLE: on rise, go to RECV. Clear bit_cnt, word_cnt, idle_cnt, pad_err_o and len_err_o. Shift in the first bit. busy_o=1.
  - RECV, on each rise: shift bit into a 24-bit register; bit_cnt++; idle_cnt=0.
  - RECV, on the rise that makes bit_cnt == 24:
    - If word_cnt < LED_NUM: next cycle valid_o=1, data_o/led_idx_o=word_cnt, pad check.
    - If word_cnt >= LED_NUM: no valid_o; set overflow flag.
    - In both cases: word_cnt++ (saturating at 2^IDX_W-1); bit_cnt=0.
  - RECV, no rise: idle_cnt++. When idle_cnt reaches IDLE_CNT-1:
    - Next cycle frame_done_o=1 for one cycle.
    - len_err_o = (word_cnt != LED_NUM) | (bit_cnt != 0) | overflow.
    - Go to IDLE; busy_o=0.
    - Partial word is discarded.
- Latency: valid_o is asserted on the 3rd clk edge after the edge that first samples cko_i high for the 24th bit. data_o/led_idx_o hold until the next valid_o.
- Simultaneity: a rise in the same cycle idle_cnt would expire takes priority; the frame continues and idle_cnt clears.
- Hold behaviour: len_err_o and pad_err_o hold after frame_done_o until the next frame start.
- Reset mid-frame: everything returns to reset values; no frame_done_o is issued; armed re-evaluates.
- cko period below 4 clk cycles is unsupported (edges may merge); no detection required.

Test Plan:
- Nominal frame: 35 words at cko = clk/5, word i = {i[3:0],F,~i[3:0],F,4'h5,F} -> 35 valid_o strobes, led_idx_o 0..34, data_o = {i[3:0],~i[3:0],4'h5}; one frame_done_o after 16 idle cycles; len_err_o=0, pad_err_o=0.
- Short frame: 34 full words plus 10 extra bits -> 34 valid_o; frame_done_o with len_err_o=1. A following correct frame gives len_err_o=0.
- Long frame: 36 words -> exactly 35 valid_o (idx 0..34); the 36th is suppressed; len_err_o=1.
- Pad error: word 7 pad nibble after G = 4'hE -> valid_o still fires with data intact; pad_err_o=1 from that word through frame_done_o; cleared on next frame's first rise.
- Reset cases:
  - cko_i held high while rst deasserts -> no valid_o and busy_o=0 until cko_i goes low then high.
  - rst pulsed mid-word 12 -> no frame_done_o.
  - A new full frame after that reset decodes idx 0..34 cleanly.
- Boundary timing: gap of exactly IDLE_CNT-1 clk cycles between bits -> frame continues. A gap of IDLE_CNT cycles -> frame_done_o.

Source files
------------

// File: rtl/led_stream_rx.sv
// LED serial-link receiver: oversamples the cko/sdo pair on clk, rebuilds
// 24-bit LED words, strips the pad nibbles and reports per-word data plus
// frame completion with length and padding error flags.
module led_stream_rx #(
  parameter int LED_NUM  = 35,
  parameter int IDLE_CNT = 16,
  parameter int IDX_W    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cko_i,
  input  logic             sdo_i,
  output logic [11:0]      data_o,
  output logic             valid_o,
  output logic [IDX_W-1:0] led_idx_o,
  output logic             frame_done_o,
  output logic             len_err_o,
  output logic             pad_err_o,
  output logic             busy_o
);

  localparam int IC_W = (IDLE_CNT > 2) ? $clog2(IDLE_CNT) : 1;
  localparam logic [IC_W-1:0]  IDLE_MAX  = IC_W'(IDLE_CNT - 1);
  localparam logic [IDX_W-1:0] LED_NUM_W = IDX_W'(LED_NUM);
  localparam logic [IDX_W-1:0] WORD_MAX  = {IDX_W{1'b1}};

  typedef enum logic {
    ST_IDLE,
    ST_RECV
  } state_t;

  // synchroniser and arming state
  logic       cko_s1_q, cko_s2_q, cko_s3_q;
  logic       sdo_s1_q, sdo_s2_q;
  logic [1:0] sync_vld_q;
  logic       armed_q;

  // receive state
  state_t           state_q;
  logic [23:0]      shift_q;
  logic [4:0]       bit_cnt_q;
  logic [IDX_W-1:0] word_cnt_q;
  logic [IC_W-1:0]  idle_cnt_q;
  logic             overflow_q;
  logic             emit_q;
  logic [IDX_W-1:0] emit_idx_q;

  // registered outputs
  logic             valid_q;
  logic [11:0]      data_q;
  logic [IDX_W-1:0] idx_q;
  logic             frame_done_q;
  logic             len_err_q;
  logic             pad_err_q;
  logic             busy_q;

  logic             cko_rise;
  logic [23:0]      shift_d;
  logic [IDX_W-1:0] word_cnt_d;
  logic             pad_bad;

  assign cko_rise   = cko_s2_q & ~cko_s3_q & armed_q;
  assign shift_d    = {shift_q[22:0], sdo_s2_q};
  assign word_cnt_d = (word_cnt_q == WORD_MAX) ? word_cnt_q : word_cnt_q + IDX_W'(1);
  assign pad_bad    = (shift_q[19:16] != 4'hF) | (shift_q[11:8] != 4'hF) |
                      (shift_q[3:0] != 4'hF);

  // Double-register the async inputs; arm only once a real low level of cko
  // has reached s2 (sync_vld_q tracks that s2 no longer holds its reset value),
  // so a cko held high through reset cannot fake a rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cko_s1_q   <= 1'b0;
      cko_s2_q   <= 1'b0;
      cko_s3_q   <= 1'b0;
      sdo_s1_q   <= 1'b0;
      sdo_s2_q   <= 1'b0;
      sync_vld_q <= 2'b00;
      armed_q    <= 1'b0;
    end else begin
      cko_s1_q   <= cko_i;
      cko_s2_q   <= cko_s1_q;
      cko_s3_q   <= cko_s2_q;
      sdo_s1_q   <= sdo_i;
      sdo_s2_q   <= sdo_s1_q;
      sync_vld_q <= {sync_vld_q[0], 1'b1};
      if (sync_vld_q[1] && !cko_s2_q) begin
        armed_q <= 1'b1;
      end
    end
  end

  // Frame FSM: bit/word counting, idle timeout, and the output stage that
  // publishes a completed word one cycle after its last bit was shifted in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      overflow_q   <= 1'b0;
      emit_q       <= 1'b0;
      emit_idx_q   <= '0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      idx_q        <= '0;
      frame_done_q <= 1'b0;
      len_err_q    <= 1'b0;
      pad_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
      emit_q       <= 1'b0;

      // shift_q still holds the finished word here: the next cko edge is
      // at least four clk cycles away.
      if (emit_q) begin
        valid_q <= 1'b1;
        data_q  <= {shift_q[23:20], shift_q[15:12], shift_q[7:4]};
        idx_q   <= emit_idx_q;
        if (pad_bad) begin
          pad_err_q <= 1'b1;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (cko_rise) begin
            state_q    <= ST_RECV;
            shift_q    <= shift_d;
            bit_cnt_q  <= 5'd1;
            word_cnt_q <= '0;
            idle_cnt_q <= '0;
            overflow_q <= 1'b0;
            pad_err_q  <= 1'b0;
            len_err_q  <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ST_RECV: begin
          if (cko_rise) begin
            // an edge always wins over an expiring idle counter
            shift_q    <= shift_d;
            idle_cnt_q <= '0;
            if (bit_cnt_q == 5'd23) begin
              bit_cnt_q  <= '0;
              word_cnt_q <= word_cnt_d;
              if (word_cnt_q < LED_NUM_W) begin
                emit_q     <= 1'b1;
                emit_idx_q <= word_cnt_q;
              end else begin
                overflow_q <= 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
            end
          end else if (idle_cnt_q == IDLE_MAX) begin
            // frame over; any partial word is simply dropped
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b1;
            len_err_q    <= (word_cnt_q != LED_NUM_W) | (bit_cnt_q != 5'd0) | overflow_q;
            idle_cnt_q   <= '0;
            bit_cnt_q    <= '0;
          end else begin
            idle_cnt_q <= idle_cnt_q + IC_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign led_idx_o    = idx_q;
  assign frame_done_o = frame_done_q;
  assign len_err_o    = len_err_q;
  assign pad_err_o    = pad_err_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_led_stream_rx.sv
// Bench for led_stream_rx: bit streams are built in queues, a frame-level
// reference model turns them into expected words/frame results, and a
// monitor compares every valid_o / frame_done_o against those queues.
module tb_led_stream_rx;

  localparam int LED_NUM  = 35;
  localparam int IDLE_CNT = 16;
  localparam int IDX_W    = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cko_i = 1'b1;
  logic             sdo_i = 1'b0;
  logic [11:0]      data_o;
  logic             valid_o;
  logic [IDX_W-1:0] led_idx_o;
  logic             frame_done_o;
  logic             len_err_o;
  logic             pad_err_o;
  logic             busy_o;

  led_stream_rx #(.LED_NUM(LED_NUM), .IDLE_CNT(IDLE_CNT), .IDX_W(IDX_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .cko_i        (cko_i),
    .sdo_i        (sdo_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .led_idx_o    (led_idx_o),
    .frame_done_o (frame_done_o),
    .len_err_o    (len_err_o),
    .pad_err_o    (pad_err_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // stimulus: one entry per serial bit, with the rise-to-rise period (clk cycles)
  bit bit_q[$];
  int per_q[$];
  bit cur_bits[$];

  // scoreboard queues
  logic [11:0] exp_data[$];
  int          exp_idx[$];
  bit          exp_pad[$];
  bit          exp_len[$];
  bit          exp_fpad[$];
  bit          last_len = 1'b0;
  bit          last_pad = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] nom_word(input int i);
    logic [3:0] n;
    n = i[3:0];
    return {n, 4'hF, ~n, 4'hF, 4'h5, 4'hF};
  endfunction

  function automatic int rand_per();
    if (bit_q.size() > 40 && $urandom_range(0, 299) == 0) return int'($urandom_range(16, 17));
    return int'($urandom_range(4, 8));
  endfunction

  // append the first nbits of w, MSB first; p==0 picks a random period per bit
  task automatic add_bits(input logic [23:0] w, input int nbits, input int p);
    for (int b = 23; b > 23 - nbits; b--) begin
      per_q.push_back((p == 0) ? rand_per() : p);
      bit_q.push_back(w[b]);
    end
  endtask

  // Reference model for one frame held in cur_bits: whole 24-bit words are
  // counted, the first LED_NUM are reported, leftovers/overflow flag len_err.
  task automatic close_frame(input bit has_end);
    int nfull;
    int rem;
    bit pad_seen;
    logic [23:0] word;
    nfull = cur_bits.size() / 24;
    rem   = cur_bits.size() % 24;
    pad_seen = 1'b0;
    for (int w = 0; w < nfull && w < LED_NUM; w++) begin
      for (int b = 0; b < 24; b++) word[23-b] = cur_bits[w*24+b];
      if (word[19:16] != 4'hF || word[11:8] != 4'hF || word[3:0] != 4'hF) pad_seen = 1'b1;
      exp_data.push_back({word[23:20], word[15:12], word[7:4]});
      exp_idx.push_back(w);
      exp_pad.push_back(pad_seen);
    end
    if (has_end) begin
      last_len = (nfull != LED_NUM) || (rem != 0);
      last_pad = pad_seen;
      exp_len.push_back(last_len);
      exp_fpad.push_back(last_pad);
    end
  endtask

  // Split the stream into frames wherever a gap reaches IDLE_CNT empty
  // cycles, push expectations, then drive it; abort ends with a reset pulse.
  task automatic run_stream(input bit abort);
    cur_bits.delete();
    for (int k = 0; k < bit_q.size(); k++) begin
      if (k > 0 && per_q[k] - 1 >= IDLE_CNT) begin
        close_frame(1'b1);
        cur_bits.delete();
      end
      cur_bits.push_back(bit_q[k]);
    end
    close_frame(!abort);

    for (int k = 0; k < bit_q.size(); k++) begin
      cko_i = 1'b0;
      sdo_i = bit_q[k];
      repeat (per_q[k] - 2) @(negedge clk);
      cko_i = 1'b1;
      repeat (2) @(negedge clk);
      if (k == 30) check("busy_in_frame", busy_o, 1);
    end
    cko_i = 1'b0;
    if (abort) begin
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
    end else begin
      repeat (IDLE_CNT + 10) @(negedge clk);
    end
    for (int t = 0; t < 200 && (exp_idx.size() != 0 || exp_len.size() != 0); t++) @(negedge clk);
    check("scoreboard_drained", exp_idx.size() + exp_len.size(), 0);
    check("busy_after", busy_o, 0);
    if (abort) begin
      check("len_err_after_reset", len_err_o, 0);
      check("pad_err_after_reset", pad_err_o, 0);
    end else begin
      repeat (5) @(negedge clk);
      check("len_err_hold", len_err_o, last_len);
      check("pad_err_hold", pad_err_o, last_pad);
    end
    $display("stream done: bits=%0d abort=%0d errors=%0d checks=%0d", bit_q.size(), abort, errors, checks);
    bit_q.delete();
    per_q.delete();
  endtask

  // monitor: every output strobe is matched against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && valid_o) begin
        if (exp_idx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: idx=%0d data=%03h, none expected", led_idx_o, data_o);
        end else begin
          check("word_idx", led_idx_o, exp_idx.pop_front());
          check("word_data", data_o, exp_data.pop_front());
          check("word_pad_err", pad_err_o, exp_pad.pop_front());
          $display("word idx=%0d data=%03h pad_err=%0d", led_idx_o, data_o, pad_err_o);
        end
      end
      if (!rst && frame_done_o) begin
        if (exp_len.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame_done: len_err=%0d, none expected", len_err_o);
        end else begin
          check("frame_len_err", len_err_o, exp_len.pop_front());
          check("frame_pad_err", pad_err_o, exp_fpad.pop_front());
          $display("frame_done len_err=%0d pad_err=%0d", len_err_o, pad_err_o);
        end
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] w;
    // reset with cko held high: nothing may happen until cko goes low
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", valid_o, 0);
    check("rst_data", data_o, 0);
    check("rst_idx", led_idx_o, 0);
    check("rst_frame_done", frame_done_o, 0);
    check("rst_len_err", len_err_o, 0);
    check("rst_pad_err", pad_err_o, 0);
    check("rst_busy", busy_o, 0);
    repeat (20) @(negedge clk);
    check("busy_cko_high", busy_o, 0);
    cko_i = 1'b0;
    repeat (5) @(negedge clk);

    // nominal frame at clk/5
    for (int i = 0; i < LED_NUM; i++) add_bits(nom_word(i), 24, 5);
    run_stream(1'b0);

    // short frame: 34 words plus 10 bits
    for (int i = 0; i < LED_NUM - 1; i++) add_bits(nom_word(i), 24, 5);
    add_bits(nom_word(34), 10, 5);
    run_stream(1'b0);

    // correct frame clears len_err
    for (int i = 0; i < LED_NUM; i++) add_bits(nom_word(i + 3), 24, 5);
    run_stream(1'b0);

    // long frame: 36 words
    for (int i = 0; i < LED_NUM + 1; i++) add_bits(nom_word(i), 24, 5);
    run_stream(1'b0);

    // pad error on word 7 (nibble after G)
    for (int i = 0; i < LED_NUM; i++) begin
      w = nom_word(i);
      if (i == 7) w[11:8] = 4'hE;
      add_bits(w, 24, 5);
    end
    run_stream(1'b0);

    // reset in the middle of word 12, then a clean frame
    for (int i = 0; i < 12; i++) add_bits(nom_word(i), 24, 5);
    add_bits(nom_word(12), 10, 5);
    run_stream(1'b1);
    for (int i = 0; i < LED_NUM; i++) add_bits(nom_word(i + 9), 24, 5);
    run_stream(1'b0);

    // gap of IDLE_CNT-1 empty cycles keeps the frame alive
    for (int i = 0; i < LED_NUM; i++) add_bits(nom_word(i), 24, 5);
    per_q[100] = IDLE_CNT;
    run_stream(1'b0);

    // gap of IDLE_CNT empty cycles before word 20 splits the frame
    for (int i = 0; i < LED_NUM; i++) add_bits(nom_word(i), 24, 5);
    per_q[20*24] = IDLE_CNT + 1;
    run_stream(1'b0);

    // randomized frames: lengths, trailing bits, data, pads and periods
    for (int f = 0; f < 3; f++) begin
      int nw;
      nw = int'($urandom_range(LED_NUM - 1, LED_NUM + 1));
      for (int i = 0; i < nw; i++) begin
        w = {4'($urandom), 4'hF, 4'($urandom), 4'hF, 4'($urandom), 4'hF};
        if ($urandom_range(0, 39) == 0) w[19:16] = 4'($urandom_range(0, 14));
        if ($urandom_range(0, 39) == 0) w[3:0]   = 4'($urandom_range(0, 14));
        add_bits(w, 24, 0);
      end
      if ($urandom_range(0, 2) == 0) add_bits(24'($urandom), int'($urandom_range(1, 23)), 0);
      run_stream(1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
